i2s_tx: RTL and testbench
=========================

# i2s_tx

I2S master transmitter. It generates SCK and WS from `clk` with the same prescaler scheme as the I2S receiver. It buffers outgoing channel words in an internal FIFO and shifts them out MSB-first on `sdo`, in either Philips I2S or left-justified format. It sits between the bus-facing register wrapper (FIFO writes, configuration) and the DAC/codec pins, and pairs with the receiver block on the same frame timing.

## Interface
- `AW`, 4: FIFO address width; depth = 2^AW words.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: transmitter enable; low = synchronous idle.
- `sck_prescaler` input 8: SCK half-period minus one, in `clk` cycles.
- `left_justified` input 1: 1 = left-justified, 0 = Philips I2S (1-SCK data delay).
- `sample_size` input 6: bits per channel word, 1..32; 0 or >32 is treated as 32.
- `channels` input 2: bit1 = left (ws=0) enabled, bit0 = right (ws=1) enabled.
- `fifo_wr` input 1: write strobe.
- `fifo_wdata` input 32: channel word; the low `sample_size` bits are transmitted.
- `fifo_flush` input 1: synchronous FIFO empty.
- `fifo_level_threshold` input AW+1: refill threshold.
- `underflow_clr` input 1: clears `underflow`.
- `fifo_full` output 1; `fifo_empty` output 1; `fifo_level` output AW+1.
- `fifo_level_below` output 1: `fifo_level < fifo_level_threshold`.
- `underflow` output 1: sticky; set when an enabled slot found the FIFO empty.
- `sck` output 1; `ws` output 1; `sdo` output 1.

## Operation
- Reset values: sck=0, ws=1, sdo=0, underflow=0, FIFO empty (level=0, empty=1, full=0), prescaler=0, bit_ctr=0, shifter=0.
- Prescaler: while `en`=1, if prescaler==0 reload `sck_prescaler` and assert tick; else decrement. SCK toggles on tick. SCK period = 2*(sck_prescaler+1) clk.
- Falling tick (tick with sck=1):
  - bit_ctr (5 bits, wraps) increments.
  - ws toggles when bit_ctr==0.
  - Result: 32 SCK per channel slot, 64 per frame, left slot first after enable.
- Load point, on a falling tick:
  - bit_ctr==0 when left_justified=1, bit_ctr==1 when left_justified=0.
  - The slot's channel is ws as it stands after that tick.
  - Channel enabled and FIFO non-empty: pop the head; shifter = word << (32-N), where N = effective sample_size.
  - Channel enabled and FIFO empty: shifter = 0, set `underflow`, no pop.
  - Channel disabled: shifter = 0, no pop.
- On every other falling tick, shifter <<= 1 with a zero fill. `sdo` is registered from shifter[31], so it changes only on falling ticks, in the same clk as the sck fall. The receiver samples on rising SCK.
- Philips mode: slot bit 0 carries the previous shifter's residual bit, which is 0 unless N=32.
- `en`=0 synchronously forces prescaler, sck, bit_ctr and shifter to 0 and ws to 1. The FIFO and `underflow` are retained, and FIFO writes remain accepted.
- FIFO write: `fifo_wr` with full=1 is dropped, even if a pop occurs in the same cycle. `fifo_wr` with an internal pop in the same cycle while non-full: level unchanged.
- `fifo_flush` has priority over both write and pop in the same cycle. The FIFO ends empty and the pop is treated as an empty slot, which sets `underflow` if that channel is enabled.
- `underflow_clr` and a new underflow in the same cycle: set wins.

## Timing
- `fifo_wr` → level, empty and full update in the next cycle. `fifo_level_below` is combinational from level.
- `en` rising at cycle 0 with sck_prescaler=P:
  - First tick at cycle 0 → sck=1 at cycle 1.
  - First falling tick at cycle P+1 → ws=0 at cycle P+2.
  - Left-justified: MSB on sdo at cycle P+2.
  - Philips: MSB on sdo 2(P+1) cycles later.
- Pop occurs in the load-tick cycle. A word written at least 1 cycle before the load tick is eligible.

## Configuration
- `I2S_TX_HOLD_EN`
  - Defined: an underflowing enabled slot reloads the last popped word for that channel, held in two per-channel registers that reset to 0, instead of 0. `underflow` is still set.
  - Undefined: zeros are sent and the hold registers are not built.

## Test plan
- P=0, LJ, size 16, channels=11, write 0x1234 then 0xABCD: left slot sdo = 0001001000110100 then 16 zeros; right slot = 1010101111001101 then 16 zeros; ws low for 64 clk then high for 64 clk.
- Same stimulus, Philips mode: each slot's first bit is 0, the MSB appears one SCK after the ws edge, and the LSB lands at slot bit 16.
- P=3: sck period 8 clk; ws edges and sdo transitions coincide only with sck falls; size 32 word 0x80000001 → first and last slot bits are 1.
- channels=10, write 3 words: only left slots pop; right slots send 0; fifo_level decrements once per frame; no underflow while words remain, then `underflow`=1 on the fourth left slot and stays 1 until `underflow_clr`.
- Write 2^AW+1 words with en=0: full=1, level=16, last word dropped; `fifo_flush` → level 0 next cycle; `fifo_level_below`=1 with threshold 4.
- Deassert en mid-slot: sck=0, ws=1, sdo=0 next cycle; re-enable restarts at the left slot with the next FIFO word intact. With `I2S_TX_HOLD_EN`, an underflow repeats the prior word.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter. Derives SCK/WS from clk through a
// programmable prescaler, buffers channel words in a 2^AW-deep FIFO and
// shifts them out MSB-first on sdo in Philips I2S or left-justified format.
// Optional build macro I2S_TX_HOLD_EN: an underflowing enabled slot repeats
// the last word popped for that channel instead of sending zeros.
module i2s_tx #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [7:0]    sck_prescaler,
    input  logic          left_justified,
    input  logic [5:0]    sample_size,
    input  logic [1:0]    channels,
    input  logic          fifo_wr,
    input  logic [31:0]   fifo_wdata,
    input  logic          fifo_flush,
    input  logic [AW:0]   fifo_level_threshold,
    input  logic          underflow_clr,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   fifo_level,
    output logic          fifo_level_below,
    output logic          underflow,
    output logic          sck,
    output logic          ws,
    output logic          sdo
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]    prescaler;
    logic [4:0]    bit_ctr;
    logic [31:0]   shifter;
    logic [31:0]   shifter_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   head;
    logic [5:0]    lshift;
    logic          tick;
    logic          fall_tick;
    logic          ws_after;
    logic          load;
    logic          chan_en;
    logic          pop;
    logic          uf_evt;
    logic          wr_ok;

`ifdef I2S_TX_HOLD_EN
    logic [31:0]   hold_l;
    logic [31:0]   hold_r;
`endif

    // Out-of-range sizes fall back to a full 32-bit word.
    function automatic logic [5:0] eff_size(input logic [5:0] s);
        return (s == 6'd0 || s > 6'd32) ? 6'd32 : s;
    endfunction

    // Frame timing decode: SCK ticks, load point and slot channel selection.
    always_comb begin
        tick      = en && (prescaler == 8'd0);
        fall_tick = tick && sck;
        ws_after  = (fall_tick && bit_ctr == 5'd0) ? ~ws : ws;
        load      = fall_tick && (left_justified ? (bit_ctr == 5'd0) : (bit_ctr == 5'd1));
        chan_en   = ws_after ? channels[0] : channels[1];
        head      = mem[rd_ptr];
        lshift    = 6'd32 - eff_size(sample_size);
        fifo_empty       = (fifo_level == '0);
        fifo_full        = (fifo_level == (AW+1)'(DEPTH));
        fifo_level_below = (fifo_level < fifo_level_threshold);
        // A flush in the load cycle empties the FIFO, so the slot underflows.
        pop    = load && chan_en && !fifo_empty && !fifo_flush;
        uf_evt = load && chan_en && (fifo_empty || fifo_flush);
        wr_ok  = fifo_wr && !fifo_full && !fifo_flush;
    end

    // Next shifter value: load on the slot's load tick, shift on other falling ticks.
    always_comb begin
        shifter_d = shifter;
        if (!en) begin
            shifter_d = '0;
        end else if (load) begin
            shifter_d = '0;
            if (pop) begin
                shifter_d = head << lshift;
            end else if (uf_evt) begin
`ifdef I2S_TX_HOLD_EN
                shifter_d = (ws_after ? hold_r : hold_l) << lshift;
`else
                shifter_d = '0;
`endif
            end
        end else if (fall_tick) begin
            shifter_d = {shifter[30:0], 1'b0};
        end
    end

    // Prescaler, SCK, bit counter, WS, shifter and the registered serial output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            sck       <= 1'b0;
            bit_ctr   <= '0;
            ws        <= 1'b1;
            shifter   <= '0;
            sdo       <= 1'b0;
        end else begin
            shifter <= shifter_d;
            sdo     <= shifter_d[31];
            if (!en) begin
                prescaler <= '0;
                sck       <= 1'b0;
                bit_ctr   <= '0;
                ws        <= 1'b1;
            end else begin
                prescaler <= (prescaler == 8'd0) ? sck_prescaler : prescaler - 8'd1;
                if (tick) sck <= ~sck;
                if (fall_tick) begin
                    bit_ctr <= bit_ctr + 5'd1;
                    ws      <= ws_after;
                end
            end
        end
    end

    // FIFO storage; written only when the write is accepted.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= fifo_wdata;
    end

    // FIFO pointers and level; flush overrides both write and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (fifo_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky underflow flag; a new underflow beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             underflow <= 1'b0;
        else if (uf_evt)        underflow <= 1'b1;
        else if (underflow_clr) underflow <= 1'b0;
    end

`ifdef I2S_TX_HOLD_EN
    // Last word popped per channel, replayed when that channel underflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_l <= '0;
            hold_r <= '0;
        end else if (pop) begin
            if (ws_after) hold_r <= head;
            else          hold_l <= head;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with hand-computed frame patterns.
module tb_i2s_tx;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [7:0]    sck_prescaler = '0;
    logic          left_justified = 1'b1;
    logic [5:0]    sample_size = 6'd16;
    logic [1:0]    channels = 2'b11;
    logic          fifo_wr = 1'b0;
    logic [31:0]   fifo_wdata = '0;
    logic          fifo_flush = 1'b0;
    logic [AW:0]   fifo_level_threshold = 5'd4;
    logic          underflow_clr = 1'b0;
    logic          fifo_full, fifo_empty, fifo_level_below, underflow;
    logic [AW:0]   fifo_level;
    logic          sck, ws, sdo;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] cap_dat, cap_ws;
    int          cap_first, cap_span, cap_low, cap_viol;

    i2s_tx #(.AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sck_prescaler(sck_prescaler),
        .left_justified(left_justified), .sample_size(sample_size),
        .channels(channels), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .fifo_flush(fifo_flush), .fifo_level_threshold(fifo_level_threshold),
        .underflow_clr(underflow_clr), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .fifo_level_below(fifo_level_below), .underflow(underflow),
        .sck(sck), .ws(ws), .sdo(sdo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        fifo_wr    = 1'b1;
        fifo_wdata = w;
        @(negedge clk);
        fifo_wr    = 1'b0;
    endtask

    task automatic idle_off();
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Collects 64 SCK falls: sdo/ws per fall, first-fall cycle, span,
    // ws-low cycles and any ws/sdo change away from a falling SCK.
    task automatic capture();
        int n, falls, idle;
        logic psck, pws, psdo;
        cap_dat = '0; cap_ws = '0; cap_first = 0; cap_span = 0;
        cap_low = 0; cap_viol = 0;
        n = 0; falls = 0; idle = 0;
        psck = sck; pws = ws; psdo = sdo;
        while (falls < 64) begin
            @(negedge clk);
            n++;
            idle++;
            if (psck && !sck) begin
                falls++;
                idle = 0;
                cap_dat = {cap_dat[62:0], sdo};
                cap_ws  = {cap_ws[62:0], ws};
                if (falls == 1)  cap_first = n;
                if (falls == 64) cap_span = n - cap_first;
            end else if (ws !== pws || sdo !== psdo) begin
                cap_viol++;
            end
            if (ws == 1'b0) cap_low++;
            psck = sck; pws = ws; psdo = sdo;
            if (idle > 600) begin
                check("sck_timeout", 64'(falls), 64'd64);
                return;
            end
        end
    endtask

    initial begin
        logic [63:0] exp_uf_l, exp_uf_r;
`ifdef I2S_TX_HOLD_EN
        exp_uf_l = 64'h33330000_00000000;
        exp_uf_r = 64'h00000000_ABCD0000;
`else
        exp_uf_l = 64'h0;
        exp_uf_r = 64'h0;
`endif
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sck", 64'(sck), 64'd0);
        check("rst_ws", 64'(ws), 64'd1);
        check("rst_sdo", 64'(sdo), 64'd0);
        check("rst_underflow", 64'(underflow), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_full", 64'(fifo_full), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Left-justified, P=0, 16-bit, both channels
        push(32'h1234);
        push(32'hABCD);
        check("lj_level_pre", 64'(fifo_level), 64'd2);
        en = 1'b1;
        capture();
        check("lj_data", cap_dat, 64'h12340000_ABCD0000);
        check("lj_ws", cap_ws, 64'h00000000_FFFFFFFF);
        check("lj_first", 64'(cap_first), 64'd2);
        check("lj_span", 64'(cap_span), 64'd126);
        check("lj_ws_low", 64'(cap_low), 64'd64);
        check("lj_viol", 64'(cap_viol), 64'd0);
        idle_off();
        check("lj_level_post", 64'(fifo_level), 64'd0);
        check("lj_underflow", 64'(underflow), 64'd0);

        // Philips, same words
        left_justified = 1'b0;
        push(32'h1234);
        push(32'hABCD);
        en = 1'b1;
        capture();
        check("ph_data", cap_dat, 64'h091A0000_55E68000);
        check("ph_ws", cap_ws, 64'h00000000_FFFFFFFF);
        check("ph_first", 64'(cap_first), 64'd2);
        idle_off();
        check("ph_underflow", 64'(underflow), 64'd0);

        // P=3, 32-bit word, left channel only
        left_justified = 1'b1;
        sck_prescaler  = 8'd3;
        sample_size    = 6'd32;
        channels       = 2'b10;
        push(32'h80000001);
        en = 1'b1;
        capture();
        check("p3_data", cap_dat, 64'h80000001_00000000);
        check("p3_ws", cap_ws, 64'h00000000_FFFFFFFF);
        check("p3_first", 64'(cap_first), 64'd5);
        check("p3_span", 64'(cap_span), 64'd504);
        check("p3_ws_low", 64'(cap_low), 64'd256);
        check("p3_viol", 64'(cap_viol), 64'd0);
        idle_off();
        check("p3_underflow", 64'(underflow), 64'd0);

        // Left only, three words, then underflow on the fourth frame
        sck_prescaler = 8'd0;
        sample_size   = 6'd16;
        push(32'h1111);
        push(32'h2222);
        push(32'h3333);
        en = 1'b1;
        capture();
        check("l1_data", cap_dat, 64'h11110000_00000000);
        check("l1_level", 64'(fifo_level), 64'd2);
        capture();
        check("l2_data", cap_dat, 64'h22220000_00000000);
        check("l2_level", 64'(fifo_level), 64'd1);
        capture();
        check("l3_data", cap_dat, 64'h33330000_00000000);
        check("l3_level", 64'(fifo_level), 64'd0);
        check("l3_underflow", 64'(underflow), 64'd0);
        capture();
        check("l4_data", cap_dat, exp_uf_l);
        check("l4_underflow", 64'(underflow), 64'd1);
        idle_off();
        check("uf_sticky", 64'(underflow), 64'd1);
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
        check("uf_cleared", 64'(underflow), 64'd0);

        // Disable mid-slot, then restart at the left slot
        channels = 2'b11;
        push(32'h5555);
        push(32'h6666);
        en = 1'b1;
        repeat (21) @(negedge clk);
        check("mid_pre_sck", 64'(sck), 64'd1);
        check("mid_pre_sdo", 64'(sdo), 64'd1);
        check("mid_pre_ws", 64'(ws), 64'd0);
        en = 1'b0;
        @(negedge clk);
        check("off_sck", 64'(sck), 64'd0);
        check("off_ws", 64'(ws), 64'd1);
        check("off_sdo", 64'(sdo), 64'd0);
        check("off_level", 64'(fifo_level), 64'd1);
        en = 1'b1;
        capture();
        check("re_data", cap_dat, 64'h66660000_00000000 | exp_uf_r);
        check("re_first", 64'(cap_first), 64'd2);
        check("re_underflow", 64'(underflow), 64'd1);
        idle_off();
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;

        // Overfill with en=0, then flush
        for (int i = 0; i < 17; i++) push(32'h100 + 32'(i));
        check("ovf_full", 64'(fifo_full), 64'd1);
        check("ovf_level", 64'(fifo_level), 64'd16);
        check("ovf_empty", 64'(fifo_empty), 64'd0);
        check("ovf_below4", 64'(fifo_level_below), 64'd0);
        fifo_level_threshold = 5'd17;
        #1;
        check("ovf_below17", 64'(fifo_level_below), 64'd1);
        fifo_level_threshold = 5'd4;
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        check("fl_level", 64'(fifo_level), 64'd0);
        check("fl_empty", 64'(fifo_empty), 64'd1);
        check("fl_full", 64'(fifo_full), 64'd0);
        check("fl_below", 64'(fifo_level_below), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
